// File: rtl/stack_unit_pkg.sv
// Shared definitions for the stack controller and anything that decodes its
// SP op code (e.g. an external SP register).
//   SP_* : 2-bit stack-pointer op codes carried on sp_ctrl
//   state_t : controller FSM encoding (1 bit, IDLE=0, POP_WAIT=1)
package stack_unit_pkg;

  localparam logic [1:0] SP_HOLD  = 2'b00;
  localparam logic [1:0] SP_CLEAR = 2'b01;
  localparam logic [1:0] SP_INC   = 2'b10;
  localparam logic [1:0] SP_DEC   = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_POP_WAIT = 1'b1
  } state_t;

  // Encode the SP op for the coming edge; clear dominates, and a simultaneous
  // inc+dec (push/pop bypass) is a hold.
  function automatic logic [1:0] sp_op(input logic clr, input logic inc,
                                       input logic dec);
    logic [1:0] op;
    op = SP_HOLD;
    if (clr)             op = SP_CLEAR;
    else if (inc && !dec) op = SP_INC;
    else if (dec && !inc) op = SP_DEC;
    return op;
  endfunction

endpackage

// File: rtl/stack_unit_ram.sv
// stack_ram: DEPTH x n storage for the stack.
//   clk          : clock
//   we/waddr/wdata : synchronous write port
//   re/raddr     : read enable/address; rdata updates one edge after re
//   rdata        : registered read data, holds its value while re is low
// No reset on storage or read register.
module stack_ram #(
  parameter int n     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [n-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [n-1:0]  rdata
);

  logic [n-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stack_unit.sv
// stack_unit: LIFO stack controller with push/pop handshakes.
//   clk, rst_n            : clock, async active-low reset
//   clear                 : synchronous flush (highest priority)
//   push_valid/push_ready/push_data : push handshake
//   pop_req/pop_ack/pop_data        : pop request, 1-cycle ack, held data
//   sp_ctrl               : SP op for the coming edge (hold/clear/inc/dec)
//   sp                    : entry count 0..DEPTH
//   full, empty           : sp==DEPTH, sp==0
//   overflow, underflow   : sticky error flags, cleared by clear/reset
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int n     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [n-1:0]  push_data,
  input  logic          pop_req,
  output logic          pop_ack,
  output logic [n-1:0]  pop_data,
  output logic [1:0]    sp_ctrl,
  output logic [AW:0]   sp,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  state_t       state;
  logic         idle;
  logic         push_acc;
  logic         pop_acc;
  logic         push_only;
  logic         pop_only;
  logic         bypass;
  logic [n-1:0] byp_q;
  logic         sel_byp;
  logic [n-1:0] ram_rdata;
  logic [AW-1:0] raddr;

  assign idle       = (state == ST_IDLE);
  assign full       = (sp == (AW+1)'(DEPTH));
  assign empty      = (sp == '0);
  assign push_ready = idle && !full && !clear;
  assign push_acc   = push_valid && push_ready;
  assign pop_acc    = pop_req && idle && !clear && (!empty || push_acc);
  assign push_only  = push_acc && !pop_acc;
  assign pop_only   = pop_acc && !push_acc;
  assign bypass     = push_acc && pop_acc;
  assign sp_ctrl    = sp_op(clear, push_acc, pop_acc);
  assign raddr      = AW'(sp - (AW+1)'(1));

  // The FSM register doubles as the ack: it is high only in the POP_WAIT cycle.
  assign pop_ack  = (state == ST_POP_WAIT);
  // Read data comes either from the RAM read register or the bypass register;
  // both hold until the next accepted pop, so pop_data holds between acks.
  // The select resets onto the bypass register so pop_data resets to 0.
  assign pop_data = sel_byp ? byp_q : ram_rdata;

  stack_ram #(
    .n     (n),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_only),
    .waddr (sp[AW-1:0]),
    .wdata (push_data),
    .re    (pop_only),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      byp_q     <= '0;
      sel_byp   <= 1'b1;
    end else if (clear) begin
      state     <= ST_IDLE;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (idle && push_valid && full) overflow <= 1'b1;
      if (idle && pop_req && empty && !push_acc) underflow <= 1'b1;

      if (push_only) sp <= sp + (AW+1)'(1);
      if (pop_only)  sp <= sp - (AW+1)'(1);

      if (bypass) begin
        byp_q   <= push_data;
        sel_byp <= 1'b1;
      end else if (pop_only) begin
        sel_byp <= 1'b0;
      end

      if (pop_acc)      state <= ST_POP_WAIT;
      else if (!idle)   state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

  localparam int N  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [N-1:0]  push_data = '0;
  logic          pop_req = 1'b0;
  logic          pop_ack;
  logic [N-1:0]  pop_data;
  logic [1:0]    sp_ctrl;
  logic [AW:0]   sp;
  logic          full, empty, overflow, underflow;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  stack_unit #(.n(N), .DEPTH(D), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data),
    .sp_ctrl(sp_ctrl), .sp(sp), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic       pr;
    logic       clr;
    logic [1:0] ctrl;   // expected sp_ctrl before the edge
    logic       rdy;    // expected push_ready before the edge
    logic [4:0] sp;     // expected after the edge
    logic       ack;
    logic [7:0] data;
    logic       of;
    logic       uf;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic pv, logic [7:0] pd, logic pr, logic clr,
                              logic [1:0] ctrl, logic rdy, logic [4:0] s,
                              logic ack, logic [7:0] data, logic of, logic uf);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pr = pr; v.clr = clr; v.ctrl = ctrl; v.rdy = rdy;
    v.sp = s; v.ack = ack; v.data = data; v.of = of; v.uf = uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic drive(input logic pv, input logic [7:0] pd, input logic pr,
                       input logic clr);
    @(negedge clk);
    push_valid = pv; push_data = pd; pop_req = pr; clear = clr;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  logic [AW:0] ext_sp;
  logic [1:0]  op;

  initial begin
    // Test 1 / 3 / 4 / 5 (first part) directed table
    vecs[0]  = mk(1,8'h11,0,0, 2'b10,1, 1,0,8'h00,0,0);
    vecs[1]  = mk(1,8'h22,0,0, 2'b10,1, 2,0,8'h00,0,0);
    vecs[2]  = mk(1,8'h33,0,0, 2'b10,1, 3,0,8'h00,0,0);
    vecs[3]  = mk(0,8'h00,1,0, 2'b11,1, 2,1,8'h33,0,0);
    vecs[4]  = mk(0,8'h00,1,0, 2'b00,0, 2,0,8'h33,0,0);
    vecs[5]  = mk(0,8'h00,1,0, 2'b11,1, 1,1,8'h22,0,0);
    vecs[6]  = mk(0,8'h00,0,0, 2'b00,0, 1,0,8'h22,0,0);
    vecs[7]  = mk(0,8'h00,1,0, 2'b11,1, 0,1,8'h11,0,0);
    vecs[8]  = mk(0,8'h00,0,0, 2'b00,0, 0,0,8'h11,0,0);
    vecs[9]  = mk(0,8'h00,1,0, 2'b00,1, 0,0,8'h11,0,1);
    vecs[10] = mk(1,8'h5C,1,0, 2'b00,1, 0,1,8'h5C,0,1);
    vecs[11] = mk(0,8'h00,0,0, 2'b00,0, 0,0,8'h5C,0,1);
    vecs[12] = mk(1,8'h01,0,0, 2'b10,1, 1,0,8'h5C,0,1);
    vecs[13] = mk(1,8'h02,0,0, 2'b10,1, 2,0,8'h5C,0,1);
    vecs[14] = mk(1,8'h03,0,0, 2'b10,1, 3,0,8'h5C,0,1);
    vecs[15] = mk(1,8'h04,0,0, 2'b10,1, 4,0,8'h5C,0,1);
    vecs[16] = mk(1,8'h77,1,0, 2'b00,1, 4,1,8'h77,0,1);
    vecs[17] = mk(0,8'h00,0,0, 2'b00,0, 4,0,8'h77,0,1);
    vecs[18] = mk(0,8'h00,1,0, 2'b11,1, 3,1,8'h04,0,1);
    vecs[19] = mk(0,8'h00,0,1, 2'b01,0, 0,0,8'h04,0,0);
    vecs[20] = mk(1,8'h99,0,1, 2'b01,0, 0,0,8'h04,0,0);

    // Reset state
    #12;
    chk("reset_sp", 32'(sp), 0);
    chk("reset_ack", 32'(pop_ack), 0);
    chk("reset_data", 32'(pop_data), 0);
    chk("reset_flags", {30'd0, overflow, underflow}, 0);
    chk("reset_empty", 32'(empty), 1);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].pv, vecs[i].pd, vecs[i].pr, vecs[i].clr);
      #1;
      chk($sformatf("v%0d_sp_ctrl", i), 32'(sp_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_push_ready", i), 32'(push_ready), 32'(vecs[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_sp", i), 32'(sp), 32'(vecs[i].sp));
      chk($sformatf("v%0d_ack", i), 32'(pop_ack), 32'(vecs[i].ack));
      chk($sformatf("v%0d_data", i), 32'(pop_data), 32'(vecs[i].data));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].of));
      chk($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vecs[i].uf));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].sp == 0));
    end

    // Test 2: fill to DEPTH, overflow, pop while push_valid held at full
    for (int i = 0; i < D; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    #1;
    chk("full_flag", 32'(full), 1);
    chk("full_ready", 32'(push_ready), 0);
    chk("full_ctrl", 32'(sp_ctrl), 32'(2'b00));
    @(posedge clk); #1;
    chk("full_sp", 32'(sp), 16);
    chk("full_overflow", 32'(overflow), 1);
    drive(1'b1, 8'hBB, 1'b1, 1'b0);
    #1;
    chk("full_pop_ctrl", 32'(sp_ctrl), 32'(2'b11));
    @(posedge clk); #1;
    chk("full_pop_ack", 32'(pop_ack), 1);
    chk("full_pop_data", 32'(pop_data), 32'h AF);
    chk("full_pop_sp", 32'(sp), 15);
    chk("full_pop_overflow", 32'(overflow), 1);
    idle_cycle();
    chk("full_after_ack", 32'(pop_ack), 0);

    // Test 5: mirror SP register over a random push/pop/clear run
    ext_sp = '1;
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            (i == 0) || ($urandom_range(0, 31) == 0));
      #1;
      op = sp_ctrl;
      @(posedge clk);
      case (op)
        2'b01: ext_sp = '0;
        2'b10: ext_sp = ext_sp + 1'b1;
        2'b11: ext_sp = ext_sp - 1'b1;
        default: ;
      endcase
      #1;
      chk("mirror_sp", 32'(sp), 32'(ext_sp));
      if (sp > 5'(D)) chk("sp_range", 32'(sp), 32'(D));
    end

    // Test 6: async reset in POP_WAIT at sp=7
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("pre_reset_sp", 32'(sp), 7);
    chk("pre_reset_ack", 32'(pop_ack), 1);
    chk("pre_reset_data", 32'(pop_data), 32'h47);
    drive(1'b1, 8'h00, 1'b1, 1'b0);  // also set overflow-free noise inputs
    #1 rst_n = 1'b0;
    #1;
    chk("async_sp", 32'(sp), 0);
    chk("async_ack", 32'(pop_ack), 0);
    chk("async_data", 32'(pop_data), 0);
    chk("async_flags", {30'd0, overflow, underflow}, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle_cycle();
    chk("post_reset_sp", 32'(sp), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
